// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared opcodes, frame constants and FSM state types
// Purpose: opcode encodings for the ALU, UART line levels, and the state
//          enums used by the RX/TX framers and the operand sequencer.
// Ports:   none (package).
package uart_alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Shared by the receive and transmit framers.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    typedef enum logic [1:0] {
        SEQ_WAIT_A  = 2'd0,
        SEQ_WAIT_B  = 2'd1,
        SEQ_WAIT_OP = 2'd2,
        SEQ_SEND    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU
// Purpose: computes A op B, truncated to NB_DATA; unknown opcodes give 0.
// Ports:   i_a, i_b (operands), i_op (opcode) in; o_result out.
module alu
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result
);

    // Shifts by NB_DATA or more fall out naturally: zero for >>, sign for >>>.
    always_comb begin
        o_result = '0;
        case (i_op)
            NB_OP'(OP_ADD): o_result = i_a + i_b;
            NB_OP'(OP_SUB): o_result = i_a - i_b;
            NB_OP'(OP_AND): o_result = i_a & i_b;
            NB_OP'(OP_OR):  o_result = i_a | i_b;
            NB_OP'(OP_XOR): o_result = i_a ^ i_b;
            NB_OP'(OP_NOR): o_result = ~(i_a | i_b);
            NB_OP'(OP_SRA): o_result = NB_DATA'($signed(i_a) >>> i_b);
            NB_OP'(OP_SRL): o_result = i_a >> i_b;
            default:        o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_interface.sv
// rtl/alu_interface.sv - operand/opcode sequencer
// Purpose: collects A, B, OP from received bytes, registers the ALU result
//          and launches one transmit frame, ignoring bytes while sending.
// Ports:   i_clk, i_rst, i_rx_done, i_rx_data, i_tx_done, i_alu_result in;
//          o_a, o_b, o_op (ALU operands), o_result, o_tx_start out.
module alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_a,
    output logic [NB_DATA-1:0] o_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_tx_start
);

    seq_state_e         state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               launch_q, launch_d;
    logic               tx_start_q, tx_start_d;

    assign o_a        = a_q;
    assign o_b        = b_q;
    assign o_op       = op_q;
    assign o_result   = result_q;
    assign o_tx_start = tx_start_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        launch_d = 1'b0;
        case (state_q)
            SEQ_WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = SEQ_WAIT_B;
                end
            end
            SEQ_WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = SEQ_WAIT_OP;
                end
            end
            SEQ_WAIT_OP: begin
                if (i_rx_done) begin
                    op_d     = i_rx_data[NB_OP-1:0];
                    launch_d = 1'b1;
                    state_d  = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (i_tx_done) begin
                    state_d = SEQ_WAIT_A;
                end
            end
            default: state_d = SEQ_WAIT_A;
        endcase

        // One clock after OP lands the ALU output is stable: capture it and
        // raise tx_start together so the transmitter sees the new result.
        result_d   = launch_q ? i_alu_result : result_q;
        tx_start_d = launch_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= SEQ_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            launch_q   <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            launch_q   <= launch_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule

// File: rtl/baud_rate_gen.sv
// rtl/baud_rate_gen.sv - free-running baud tick generator
// Purpose: counts 0..BAUD_DIV-1 and flags the wrap cycle as a one-clock tick.
// Ports:   i_clk, i_rst (async, active high) in; o_tick out (oversample tick).
module baud_rate_gen #(
    parameter int BAUD_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // With BAUD_DIV=1 the counter sits at 0 and the tick is always high.
    always_comb begin
        o_tick = (cnt_q == CNT_LAST);
        cnt_d  = o_tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver
// Purpose: 1 start, NB_DATA data bits LSB first, stop bit; mid-bit sampling.
// Ports:   i_clk, i_rst, i_tick (baud tick), i_rx (serial line) in;
//          o_done (one-clock byte strobe), o_data (received byte) out.
module uart_rx
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_data
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    uart_state_e        state_q, state_d;
    logic [SW-1:0]      s_q, s_d;
    logic [NW-1:0]      n_q, n_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic               ferr_q, ferr_d;
    logic               sync1_q, sync2_q;
    logic               rx_s;

    assign rx_s   = sync2_q;
    assign o_data = b_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        ferr_d  = ferr_q;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_tick && (rx_s == START_BIT)) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    // Half a bit in: a line back high means it was a glitch.
                    if (s_q == S_MID) begin
                        if (rx_s == START_BIT) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // After a framing error, stay here until the line idles so a
                // held-low line is not mistaken for a new start bit.
                if (ferr_q) begin
                    if (rx_s == LINE_IDLE) begin
                        ferr_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (i_tick) begin
                    if (s_q == S_LAST) begin
                        if (rx_s == STOP_BIT) begin
                            o_done  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            ferr_q  <= 1'b0;
            sync1_q <= LINE_IDLE;
            sync2_q <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            ferr_q  <= ferr_d;
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - oversampling UART transmitter
// Purpose: sends one frame (start, NB_DATA bits LSB first, N_STOP stops).
// Ports:   i_clk, i_rst, i_tick, i_start (launch strobe), i_data (byte) in;
//          o_tx (serial line, registered), o_done (end-of-frame strobe) out.
module uart_tx
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int N_STOP     = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_done
);

    localparam int STOP_TICKS = OVERSAMPLE * N_STOP;
    localparam int SW = $clog2(STOP_TICKS) + 1;
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_TICKS - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(NB_DATA - 1);

    uart_state_e        state_q, state_d;
    logic [SW-1:0]      s_q, s_d;
    logic [NW-1:0]      n_q, n_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               pend_q, pend_d;
    logic               tx_q, tx_d;

    assign o_tx = tx_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        pend_d  = pend_q;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    shreg_d = i_data;
                end
                // Hold the request until a tick so the start bit spans
                // exactly OVERSAMPLE ticks.
                if (i_start || pend_q) begin
                    if (i_tick) begin
                        state_d = ST_START;
                        s_d     = '0;
                        pend_d  = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (s_q == STOP_LAST) begin
                        o_done  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the next state so o_tx stays aligned with state_q.
        case (state_d)
            ST_START: tx_d = START_BIT;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            pend_q  <= 1'b0;
            tx_q    <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_alu_top.sv
// rtl/uart_alu_top.sv - UART-driven ALU: receive A, B, OP, transmit result
// Purpose: wires baud generator, receiver, sequencer, ALU and transmitter.
// Ports:   i_clk (clock), i_rst (async, active high), i_data (serial RX) in;
//          o_data (serial TX, idle high) out.
module uart_alu_top
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int N_STOP     = 1,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_data,
    output logic o_data
);

    logic               brgen_valid_urx;
    logic               rx_done;
    logic [NB_DATA-1:0] rx_data;
    logic               tx_start;
    logic               tx_done;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_DATA-1:0] result;

    baud_rate_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_brgen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (brgen_valid_urx)
    );

    uart_rx #(
        .NB_DATA    (NB_DATA),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (brgen_valid_urx),
        .i_rx   (i_data),
        .o_done (rx_done),
        .o_data (rx_data)
    );

    alu_interface #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_seq (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_a          (alu_a),
        .o_b          (alu_b),
        .o_op         (alu_op),
        .o_result     (result),
        .o_tx_start   (tx_start)
    );

    alu #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_op     (alu_op),
        .o_result (alu_result)
    );

    uart_tx #(
        .NB_DATA    (NB_DATA),
        .N_STOP     (N_STOP),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_tick  (brgen_valid_urx),
        .i_start (tx_start),
        .i_data  (result),
        .o_tx    (o_data),
        .o_done  (tx_done)
    );

endmodule

// File: tb/tb_uart_alu_top.sv
// tb/tb_uart_alu_top.sv - bench for uart_alu_top
module tb_uart_alu_top;
    import uart_alu_pkg::*;

    localparam int BIT_CLKS = 16;
    localparam int NVEC     = 14;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic i_data;
    logic o_data;

    int checks      = 0;
    int failures    = 0;
    int rx_done_cnt = 0;
    logic [7:0] sb_q[$];
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    uart_alu_top dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (i_data),
        .o_data (o_data)
    );

    always @(posedge clk) begin
        if (dut.rx_done) rx_done_cnt <= rx_done_cnt + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        #1 i_data = v;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_v);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (30) @(posedge clk);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        sb_q.push_back(exp);
        send_byte(op, 1'b1);
        wait_drain();
    endtask

    // Frame decoder on o_data: samples each bit near its middle.
    initial begin : monitor
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && o_data === 1'b0) begin
                repeat (7) @(negedge clk);
                check("tx_start_bit", 8'(o_data), 8'h00);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    got[i] = o_data;
                end
                repeat (BIT_CLKS) @(negedge clk);
                check("tx_stop_bit", 8'(o_data), 8'h01);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got %h expected no frame", got);
                end else begin
                    check("tx_result", got, sb_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt0;
        rst    = 1'b1;
        i_data = 1'b1;

        vecs[0]  = '{8'h03, 8'h0C, 8'h20, 8'h0F};
        vecs[1]  = '{8'h03, 8'h0C, 8'h22, 8'hF7};
        vecs[2]  = '{8'h03, 8'h0C, 8'h24, 8'h00};
        vecs[3]  = '{8'h03, 8'h0C, 8'h25, 8'h0F};
        vecs[4]  = '{8'h03, 8'h0C, 8'h26, 8'h0F};
        vecs[5]  = '{8'h03, 8'h0C, 8'h27, 8'hF0};
        vecs[6]  = '{8'h80, 8'h02, 8'h03, 8'hE0};
        vecs[7]  = '{8'h80, 8'h02, 8'h02, 8'h20};
        vecs[8]  = '{8'hFF, 8'h01, 8'h20, 8'h00};
        vecs[9]  = '{8'h80, 8'h09, 8'h03, 8'hFF};
        vecs[10] = '{8'h80, 8'h08, 8'h02, 8'h00};
        vecs[11] = '{8'h5A, 8'h33, 8'h3F, 8'h00};
        vecs[12] = '{8'h12, 8'h34, 8'hE0, 8'h46};
        vecs[13] = '{8'h7F, 8'h01, 8'h03, 8'h3F};

        repeat (3) @(posedge clk);
        #1;
        check("reset_o_data", 8'(o_data), 8'h01);
        check("reset_seq_state", 8'(dut.u_seq.state_q), 8'(SEQ_WAIT_A));
        check("reset_result", dut.u_seq.result_q, 8'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("baud_tick", 8'(dut.brgen_valid_urx), 8'h01);
        check("idle_o_data", 8'(o_data), 8'h01);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
        end
        check("rx_done_count", 8'(rx_done_cnt), 8'(3 * NVEC));

        // Framing error: stop bit low, byte must be discarded.
        cnt0 = rx_done_cnt;
        send_byte(8'hA5, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("ferr_no_rx_done", 8'(rx_done_cnt - cnt0), 8'h00);
        check("ferr_seq_state", 8'(dut.u_seq.state_q), 8'(SEQ_WAIT_A));
        run_op(8'h21, 8'h11, 8'h20, 8'h32);

        // Short low glitch on the line.
        cnt0 = rx_done_cnt;
        #1 i_data = 1'b0;
        repeat (4) @(posedge clk);
        #1 i_data = 1'b1;
        repeat (48) @(posedge clk);
        check("glitch_no_rx_done", 8'(rx_done_cnt - cnt0), 8'h00);
        check("glitch_seq_state", 8'(dut.u_seq.state_q), 8'(SEQ_WAIT_A));
        run_op(8'h0F, 8'h03, 8'h22, 8'h0C);

        // Reset in the middle of receiving B.
        send_byte(8'h55, 1'b1);
        check("pre_reset_a", dut.u_seq.a_q, 8'h55);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #1 rst = 1'b1;
        #1;
        check("midreset_o_data", 8'(o_data), 8'h01);
        check("midreset_seq_state", 8'(dut.u_seq.state_q), 8'(SEQ_WAIT_A));
        check("midreset_a_cleared", dut.u_seq.a_q, 8'h00);
        i_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        run_op(8'h80, 8'h01, 8'h03, 8'hC0);

        check("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
